addac: RTL and testbench



---
 rtl/addac_pkg.sv | 15 +
 rtl/addac_adder.sv | 23 ++
 rtl/addac.sv | 67 ++++++
 tb/tb_addac.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/addac_pkg.sv
// Shared definitions for the addac bit-serial adder/accumulator.
package addac_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_ADD   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // Each accumulator bit resets to ACC_RST_BIT, so the reset value works at any width.
  localparam logic ACC_RST_BIT = 1'b0;
  localparam logic CARRY_RST   = 1'b0;

endpackage

// File: rtl/addac_adder.sv
// Combinational WIDTH-bit ripple adder built from a chain of full adders.
module addac_adder #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
  end

  assign co = w_c[WIDTH];

endmodule

// File: rtl/addac.sv
// Bit-serial adder/accumulator: hold/load/add/clear on every clock.
// Define ADDAC_CARRY_IN_EN to feed the carry flag back as ADD carry-in.
module addac
  import addac_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             sel0,
  input  logic             sel1,
  output logic             cout,
  output logic [WIDTH-1:0] s
);

  op_e              w_op;
  logic             w_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_co;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;

  assign w_op = op_e'({sel1, sel0});

`ifdef ADDAC_CARRY_IN_EN
  assign w_cin = r_carry;
`else
  assign w_cin = 1'b0;
`endif

  addac_adder #(.WIDTH(WIDTH)) u_adder (
    .x   (r_acc),
    .y   (a),
    .cin (w_cin),
    .sum (w_sum),
    .co  (w_co)
  );

  always_comb begin
    w_acc_nxt   = r_acc;
    w_carry_nxt = r_carry;
    case (w_op)
      OP_HOLD:  ;
      OP_LOAD:  begin w_acc_nxt = a;                    w_carry_nxt = 1'b0; end
      OP_ADD:   begin w_acc_nxt = w_sum;                w_carry_nxt = w_co; end
      OP_CLEAR: begin w_acc_nxt = '0;                   w_carry_nxt = 1'b0; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= {WIDTH{ACC_RST_BIT}};
      r_carry <= CARRY_RST;
    end else begin
      r_acc   <= w_acc_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign s    = r_acc;
  assign cout = r_carry;

endmodule

// File: tb/tb_addac.sv
// Self-checking bench for addac: WIDTH=1 and WIDTH=4 instances against an arithmetic model.
module tb_addac;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel0 = 1'b1;
  logic       sel1 = 1'b0;
  logic [0:0] a1 = 1'b1;
  logic [3:0] a4 = 4'hF;
  logic       cout1, cout4;
  logic [0:0] s1;
  logic [3:0] s4;

  int errors = 0;
  int checks = 0;

`ifdef ADDAC_CARRY_IN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  addac #(.WIDTH(1)) d1 (
    .clk(clk), .rst(rst), .a(a1), .sel0(sel0), .sel1(sel1), .cout(cout1), .s(s1)
  );
  addac #(.WIDTH(4)) d4 (
    .clk(clk), .rst(rst), .a(a4), .sel0(sel0), .sel1(sel1), .cout(cout4), .s(s4)
  );

  // Model: accumulator as a plain integer, ADD computed as full-width arithmetic.
  int m1_acc = 0, m4_acc = 0;
  int m1_c = 0, m4_c = 0;

  always @(posedge clk or negedge rst) begin
    int op, t1, t4;
    if (!rst) begin
      m1_acc <= 0; m1_c <= 0; m4_acc <= 0; m4_c <= 0;
    end else begin
      op = {sel1, sel0};
      t1 = m1_acc + int'(a1) + (CIN_EN ? m1_c : 0);
      t4 = m4_acc + int'(a4) + (CIN_EN ? m4_c : 0);
      case (op)
        1: begin m1_acc <= int'(a1); m1_c <= 0; m4_acc <= int'(a4); m4_c <= 0; end
        2: begin m1_acc <= t1 % 2; m1_c <= t1 / 2; m4_acc <= t4 % 16; m4_c <= t4 / 16; end
        3: begin m1_acc <= 0; m1_c <= 0; m4_acc <= 0; m4_c <= 0; end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp s1", int'(s1), m1_acc);
    check("cmp cout1", int'(cout1), m1_c);
    check("cmp s4", int'(s4), m4_acc);
    check("cmp cout4", int'(cout4), m4_c);
  end

  task automatic do_op(input logic [1:0] op, input logic x1, input logic [3:0] x4);
    @(negedge clk);
    {sel1, sel0} = op;
    a1 = x1;
    a4 = x4;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held across edges with LOAD presented
    #1;
    check("rst s1", int'(s1), 0);
    check("rst cout1", int'(cout1), 0);
    repeat (2) @(posedge clk);
    #2;
    check("rst hold s1", int'(s1), 0);
    check("rst hold s4", int'(s4), 0);
    @(negedge clk);
    rst = 1'b1;

    // LOAD then HOLD
    do_op(2'b01, 1'b1, 4'hA);
    check("load s1", int'(s1), 1);
    check("load cout1", int'(cout1), 0);
    check("load s4", int'(s4), 10);
    for (int i = 0; i < 3; i++) do_op(2'b00, 1'b0, 4'h0);
    check("hold s1", int'(s1), 1);
    check("hold s4", int'(s4), 10);

    // LOAD/ADD overflow
    do_op(2'b01, 1'b1, 4'hF);
    do_op(2'b10, 1'b1, 4'h1);
    check("add ovf s1", int'(s1), 0);
    check("add ovf cout1", int'(cout1), 1);
    check("add ovf s4", int'(s4), 0);
    check("add ovf cout4", int'(cout4), 1);
    do_op(2'b10, 1'b0, 4'h7);
`ifdef ADDAC_CARRY_IN_EN
    check("chain s1", int'(s1), 1);
    check("chain cout1", int'(cout1), 0);
    check("chain s4", int'(s4), 8);
    check("chain cout4", int'(cout4), 0);
    do_op(2'b10, 1'b1, 4'h8);
    check("chain2 s1", int'(s1), 0);
    check("chain2 cout1", int'(cout1), 1);
    check("chain2 s4", int'(s4), 0);
    check("chain2 cout4", int'(cout4), 1);
`else
    check("indep s1", int'(s1), 0);
    check("indep cout1", int'(cout1), 0);
    check("indep s4", int'(s4), 7);
    check("indep cout4", int'(cout4), 0);
`endif

    // Plain add without overflow
    do_op(2'b01, 1'b0, 4'h5);
    do_op(2'b10, 1'b1, 4'h3);
    check("add53 s4", int'(s4), 8);
    check("add53 cout4", int'(cout4), 0);
    check("add01 s1", int'(s1), 1);

    // CLEAR from acc!=0 with carry set
    do_op(2'b01, 1'b1, 4'hF);
    do_op(2'b10, 1'b1, 4'hF);
    check("pre-clr s4", int'(s4), 14);
    check("pre-clr cout4", int'(cout4), 1);
    do_op(2'b11, 1'b1, 4'h9);
    check("clr s4", int'(s4), 0);
    check("clr cout4", int'(cout4), 0);
    check("clr s1", int'(s1), 0);

    // Async reset pulse between edges
    do_op(2'b01, 1'b1, 4'h6);
    check("reload s1", int'(s1), 1);
    rst = 1'b0;
    #1;
    check("async s1", int'(s1), 0);
    check("async s4", int'(s4), 0);
    check("async cout4", int'(cout4), 0);
    #1;
    rst = 1'b1;

    // First edge after release executes its op
    do_op(2'b10, 1'b1, 4'h2);
    check("post-rst s1", int'(s1), 1);
    check("post-rst s4", int'(s4), 2);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
